// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: WIDTH-bit add/subtract done one nibble per clock through a single 4-bit CLA slice.
//   Parameter NIBBLES (2..8), WIDTH = 4*NIBBLES.
//   Inputs : clk, rst (sync, active-high), start, op_sub, a, b (sampled with start in IDLE).
//   Outputs: busy (RUN), done (one-cycle pulse), result, carry_out, overflow, zero.
//   Optional macro NIBBLE_SERIAL_ADD_SAT_EN: saturate result on signed overflow.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 op_sub,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 carry_out,
  output logic                 overflow,
  output logic                 zero
);
  localparam int WIDTH = 4*NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES-1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r, res_nxt, res_fin;
  logic [IW-1:0] idx;
  logic cy, c4, last, ovf;
  logic [3:0] na, nb, g, p, c, sum;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    busy = 1'b0;
    done = 1'b0;
    state_nxt = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
    busy = state == RUN;
    done = state == DONE;
  end
  // 4-bit carry-lookahead slice fed by the current nibble and the carry register
  always_comb begin
    na = a_r[{idx, 2'b00} +: 4];
    nb = b_r[{idx, 2'b00} +: 4];
    g = na & nb;
    p = na ^ nb;
    c[0] = cy;
    c[1] = g[0] | (p[0] & cy);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cy);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cy);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & cy);
    sum = p ^ c;
    res_nxt = result;
    res_nxt[{idx, 2'b00} +: 4] = sum;
  end
  assign last = idx == LAST;
  // on the MSB nibble, c[3] is the carry into bit WIDTH-1
  assign ovf = c[3] ^ c4;
`ifdef NIBBLE_SERIAL_ADD_SAT_EN
  assign res_fin = ovf ? (a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : res_nxt;
`else
  assign res_fin = res_nxt;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      cy <= 1'b0;
      idx <= '0;
      result <= '0;
      carry_out <= 1'b0;
      overflow <= 1'b0;
      zero <= 1'b0;
    end else if (state == IDLE && start) begin
      a_r <= a;
      b_r <= op_sub ? ~b : b;
      cy <= op_sub;
      idx <= '0;
      result <= '0;
      carry_out <= 1'b0;
      overflow <= 1'b0;
      zero <= 1'b0;
    end else if (state == RUN) begin
      cy <= c4;
      result <= last ? res_fin : res_nxt;
      idx <= last ? '0 : idx + 1'b1;
      if (last) begin
        carry_out <= c4;
        overflow <= ovf;
        zero <= res_fin == '0;
      end
    end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: directed table plus corner sequences for nibble_serial_add_ctrl at NIBBLES=4.
module tb_nibble_serial_add_ctrl;
`ifdef NIBBLE_SERIAL_ADD_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, op_sub = 1'b0;
  logic [15:0] a = '0, b = '0, result;
  logic busy, done, carry_out, overflow, zero;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic s;
    logic [15:0] x, y, r;
    logic co, ov, z;
  } vec_t;
  vec_t v[8];
  nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .overflow(overflow), .zero(zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic launch(input logic s, input logic [15:0] x, input logic [15:0] y, output int lat, output int bc);
    @(negedge clk);
    start = 1'b1;
    op_sub = s;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
    op_sub = ~s;
    a = ~x;
    b = ~y;
    lat = 0;
    bc = 0;
    while (!done && lat < 20) begin
      bc += int'(busy);
      lat++;
      @(negedge clk);
    end
  endtask
  task automatic run_vec(input string nm, input vec_t t);
    int lat, bc;
    launch(t.s, t.x, t.y, lat, bc);
    chk({nm, "_latency"}, lat, 4);
    chk({nm, "_busy_cycles"}, bc, 4);
    chk({nm, "_result"}, result, t.r);
    chk({nm, "_flags"}, {carry_out, overflow, zero}, {t.co, t.ov, t.z});
    @(negedge clk);
    chk({nm, "_done_pulse"}, {done, busy}, 2'b00);
    chk({nm, "_result_held"}, result, t.r);
  endtask
  initial begin
    int pulses, lat, bc;
    logic [15:0] seen;
    v[0] = '{1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0};
    v[1] = '{1'b0, 16'h7FFF, 16'h0001, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1, 1'b0};
    v[2] = '{1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1};
    v[3] = '{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    v[4] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
    v[5] = '{1'b1, 16'h8000, 16'h0001, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1, 1'b0};
    v[6] = '{1'b0, 16'h8000, 16'h8000, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1, !SAT};
    v[7] = '{1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0};
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, result, carry_out, overflow, zero}, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {busy, done, result, carry_out, overflow, zero}, '0);
    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), v[i]);
    // start held through RUN with other operands must be ignored
    @(negedge clk);
    start = 1'b1;
    op_sub = 1'b0;
    a = 16'h1234;
    b = 16'h0FFF;
    @(negedge clk);
    a = 16'hFFFF;
    b = 16'hFFFF;
    op_sub = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    pulses = 0;
    seen = '0;
    for (int k = 0; k < 10; k++) begin
      if (done) begin
        pulses++;
        seen = result;
      end
      @(negedge clk);
    end
    chk("held_start_done_count", pulses, 1);
    chk("held_start_result", seen, 16'h2233);
    chk("held_start_idle", {busy, done}, 2'b00);
    run_vec("after_held", v[7]);
    // reset on the second RUN cycle aborts the operation
    @(negedge clk);
    start = 1'b1;
    op_sub = 1'b0;
    a = 16'h1234;
    b = 16'h1111;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_outputs", {busy, done, result, carry_out, overflow, zero}, '0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      pulses += int'(done);
      @(negedge clk);
    end
    chk("abort_no_done", pulses, 0);
    chk("abort_idle_busy", busy, 1'b0);
    launch(1'b0, 16'h1234, 16'h1111, lat, bc);
    chk("post_abort_latency", lat, 4);
    chk("post_abort_result", result, 16'h2345);
    chk("post_abort_flags", {carry_out, overflow, zero}, 3'b000);
    // rst and start together: rst wins
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("rst_beats_start", {busy, done, result}, '0);
    @(negedge clk);
    chk("rst_beats_start_idle", busy, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
